// File: rtl/ldpc_pkg.sv
// Shared constants and types for the LDPC prototype-matrix walker.
// Every block that reads the rate-5/6 prototype matrix imports this package.
package ldpc_pkg;

  localparam int PROTO_ROWS = 4;
  localparam int PROTO_COLS = 24;

  // A ROM entry with all bits set marks a zero block ("-").
  function automatic logic [31:0] skip_val(input int width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // The shift field is sized for the largest lifting size, Z=81.
  typedef struct packed {
    logic [$clog2(PROTO_ROWS)-1:0] row;
    logic [$clog2(PROTO_COLS)-1:0] col;
    logic [6:0]                    shift;
    logic                          row_first;
  } proto_tuple_t;

endpackage

// File: rtl/proto_rowcol_counter.sv
// Row/column scan counter for the prototype matrix.
// Keeps the linear ROM address registered alongside the row and column.
module proto_rowcol_counter #(
  parameter int ROWS  = 4,
  parameter int COLS  = 24,
  parameter int ADDRW = 7,
  parameter int RW    = $clog2(ROWS),
  parameter int CW    = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [RW-1:0]    row,
  output logic [CW-1:0]    col,
  output logic [ADDRW-1:0] addr,
  output logic             col_last,
  output logic             all_last
);

  assign col_last = (col == CW'(COLS - 1));
  assign all_last = col_last && (row == RW'(ROWS - 1));

  // Row-major order, so the address is a plain increment that wraps with the matrix.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (advance) begin
      if (col_last) begin
        col <= '0;
        row <= all_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
      addr <= all_last ? '0 : addr + ADDRW'(1);
    end
  end

endmodule

// File: rtl/proto_matrix_walker.sv
// Walks the prototype-matrix ROM and streams non-zero blocks as
// (row, col, shift) tuples over a valid/ready interface.
module proto_matrix_walker
  import ldpc_pkg::*;
#(
  parameter int Z     = 54,
  parameter int WIDTH = $clog2(Z),
  parameter int ROWS  = PROTO_ROWS,
  parameter int COLS  = PROTO_COLS,
  parameter int DEPTH = ROWS * COLS,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDRW-1:0]        rom_addr,
  input  logic [WIDTH-1:0]        rom_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(ROWS)-1:0] out_row,
  output logic [$clog2(COLS)-1:0] out_col,
  output logic [WIDTH-1:0]        out_shift,
  output logic                    out_row_first,
  output logic [ADDRW:0]          blk_cnt
);

  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int TRW = $clog2(PROTO_ROWS);
  localparam int TCW = $clog2(PROTO_COLS);
  localparam logic [31:0]      SKIP_WORD = skip_val(WIDTH);
  localparam logic [WIDTH-1:0] SKIP      = SKIP_WORD[WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t       state;
  proto_tuple_t tup;
  logic         row_seen;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic col_last, all_last, adv, step, start_ok;

  assign adv      = !out_valid || out_ready;
  assign step     = (state == SCAN) && adv;
  assign start_ok = (state == IDLE) && start && !done;

  proto_rowcol_counter #(
    .ROWS(ROWS), .COLS(COLS), .ADDRW(ADDRW)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .advance  (step),
    .row      (cur_row),
    .col      (cur_col),
    .addr     (rom_addr),
    .col_last (col_last),
    .all_last (all_last)
  );

  assign out_row       = RW'(tup.row);
  assign out_col       = CW'(tup.col);
  assign out_shift     = tup.shift[WIDTH-1:0];
  assign out_row_first = tup.row_first;

  // A stalled tuple freezes the whole scan; DRAIN only waits for the last handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tup       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      blk_cnt   <= '0;
      row_seen  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state    <= SCAN;
            busy     <= 1'b1;
            blk_cnt  <= '0;
            row_seen <= 1'b0;
          end
        end
        SCAN: begin
          if (adv) begin
            if (rom_data != SKIP) begin
              tup.row       <= TRW'(cur_row);
              tup.col       <= TCW'(cur_col);
              tup.shift     <= 7'(rom_data);
              tup.row_first <= !row_seen;
              out_valid     <= 1'b1;
              blk_cnt       <= blk_cnt + (ADDRW+1)'(1);
              row_seen      <= 1'b1;
            end else begin
              out_valid <= 1'b0;
            end
            if (col_last) row_seen <= 1'b0;
            if (all_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (adv) begin
            done      <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
